instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15, is the maximum number of cycles spent in FETCH waiting for mem_ack.
REQ-002 Parameter MAX_OPE_LEN, default 6, is the largest legal instruction length in bytes.
REQ-003 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 run  in  1  level; high means continuous execution.
REQ-006 step  in  1  one-cycle pulse; runs one instruction while run=0.
REQ-007 mem_ack  in  1  fetch memory has presented the instruction word this cycle.
REQ-008 num_of_ope  in  4  instruction byte length from decode; valid from the cycle after the decode pulse.
REQ-009 reg_load_2  in  4  second-stage destination from decode; 0 means single-stage instruction.
REQ-010 halt_op  in  1  decoded opcode is HLT (F4h); valid with num_of_ope.
REQ-011 fetch_req  out  1  request to fetch memory.
REQ-012 phase  out  8  one-hot phase strobes: [0] fetch latch, [1] decode, [2] select 1, [3] execute/write 1, [4] select 2, [5] execute/write 2, [6] writeback/stack, [7] eip advance.
REQ-013 busy  out  1  high in every state except IDLE, HALT and FAULT.
REQ-014 halted  out  1  HLT retired.
REQ-015 fault  out  1  fetch timeout or illegal length.
REQ-016 retired  out  32  count of completed instructions.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, DECODE, SEL1, EXEC1, SEL2, EXEC2, WB, ADV, HALT and FAULT.
REQ-018 IDLE SHALL go to FETCH when run=1 or step=1; otherwise it stays in IDLE.
REQ-019 FETCH behaviour:
- fetch_req=1 throughout the state.
- When mem_ack=1: phase[0] pulses for that cycle and the next state is DECODE.
- The wait counter increments each cycle without mem_ack; reaching FETCH_TIMEOUT goes to FAULT.
REQ-020 DECODE SHALL pulse phase[1] for one cycle and go to SEL1.
REQ-021 SEL1 SHALL check its inputs in this priority order:
- num_of_ope = 0 or num_of_ope > MAX_OPE_LEN: go to FAULT with no phase[2].
- Otherwise halt_op=1: go to HALT.
- Otherwise: pulse phase[2] and go to EXEC1.
REQ-022 EXEC1 SHALL pulse phase[3], then go to SEL2 if reg_load_2 != 0, else to WB.
REQ-023 SEL2 SHALL pulse phase[4] and go to EXEC2; EXEC2 SHALL pulse phase[5] and go to WB.
REQ-024 WB SHALL pulse phase[6] and go to ADV.
REQ-025 ADV behaviour:
- Pulse phase[7] and increment retired (wraps from FFFFFFFFh to 0).
- Go to FETCH if run=1, else to IDLE.
REQ-026 At most one phase bit SHALL be high in any cycle; phase SHALL be 0 in IDLE, HALT, FAULT and in FETCH cycles without mem_ack.
REQ-027 Latency from mem_ack (zero-wait) to phase[7] inclusive SHALL be 6 cycles for a single-stage instruction and 8 cycles for a two-stage instruction.
REQ-028 Deasserting run mid-instruction SHALL complete the current instruction, then go to IDLE.
REQ-029 step SHALL be ignored while busy=1 or run=1.
REQ-030 mem_ack outside FETCH SHALL be ignored.
REQ-031 HALT SHALL set halted=1 without incrementing retired, and the HALT state is held until reset.
REQ-032 FAULT SHALL set fault=1, and the FAULT state is held until reset.

Reset
REQ-033 reset low SHALL give: state IDLE; phase=0; fetch_req=0; busy=0; halted=0; fault=0; retired=0; wait counter=0.
REQ-034 reset asserted mid-instruction SHALL abort the instruction with no further strobes, and retired is not incremented.

Structure
REQ-035 The state encoding, the phase bit index constants, and the defaults for FETCH_TIMEOUT and MAX_OPE_LEN SHALL reside in shared package cpu_pkg.
REQ-036 The fetch wait counter and timeout compare SHALL be a sub-module, seq_watchdog (inputs clk, reset, clear, count; output expired).

Verification
REQ-037 run=1, mem_ack tied high, num_of_ope=2, reg_load_2=0 -> phase sequence 01h,02h,04h,08h,40h,80h repeating every 6 cycles; retired=1 after the first 80h.
REQ-038 Same stimulus with reg_load_2=3 -> sequence 01h,02h,04h,08h,10h,20h,40h,80h; period 8.
REQ-039 run=1, mem_ack held low -> fetch_req high for 15 cycles, then fault=1, busy=0, phase=0 permanently.
REQ-040 run=0, step pulse, num_of_ope=1 -> exactly one instruction, retired=1, then IDLE; a second step during busy is ignored.
REQ-041 halt_op=1 on the 3rd instruction -> halted=1, retired=2, no phase[2] for that instruction.
REQ-042 reset low during EXEC1 -> all outputs at reset values in the same cycle; retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, phase strobe
// indices and default timing/length limits.
package cpu_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StSel1,
        StExec1,
        StSel2,
        StExec2,
        StWb,
        StAdv,
        StHalt,
        StFault
    } state_t;

    localparam int unsigned PhFetch  = 0;
    localparam int unsigned PhDecode = 1;
    localparam int unsigned PhSel1   = 2;
    localparam int unsigned PhExec1  = 3;
    localparam int unsigned PhSel2   = 4;
    localparam int unsigned PhExec2  = 5;
    localparam int unsigned PhWb     = 6;
    localparam int unsigned PhAdv    = 7;

    localparam int unsigned FetchTimeoutDefault = 15;
    localparam int unsigned MaxOpeLenDefault    = 6;

    function automatic logic [7:0] phase_strobe(input int unsigned idx);
        phase_strobe = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Fetch wait counter: counts stalled fetch cycles and flags the cycle on which
// the count reaches TIMEOUT.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned      CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]  Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    // Expiry is flagged on the stalled cycle that brings the count to TIMEOUT.
    assign expired = count && (cnt_q == Last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps each instruction through fetch, decode, one or two
// select/execute stages, writeback and EIP advance, emitting one-hot phase strobes.
module instr_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = cpu_pkg::FetchTimeoutDefault,
    parameter int unsigned MAX_OPE_LEN   = cpu_pkg::MaxOpeLenDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        mem_ack,
    input  logic [3:0]  num_of_ope,
    input  logic [3:0]  reg_load_2,
    input  logic        halt_op,
    output logic        fetch_req,
    output logic [7:0]  phase,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    import cpu_pkg::*;

    localparam logic [3:0] MaxLen = 4'(MAX_OPE_LEN);

    state_t      state_q, state_d;
    logic        fetch_req_q, busy_q, halted_q, fault_q;
    logic [31:0] retired_q;
    logic        wd_clear, wd_count, wd_expired;

    assign wd_count = (state_q == StFetch) && !mem_ack;
    assign wd_clear = (state_q != StFetch) || mem_ack;

    seq_watchdog #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .count   (wd_count),
        .expired (wd_expired)
    );

    // Phase strobes are decoded from the current state; fetch latch and select 1
    // also depend on this cycle's inputs, so they cannot be pre-registered.
    always_comb begin
        state_d = state_q;
        phase   = '0;
        unique case (state_q)
            StIdle: begin
                if (run || step) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ack) begin
                    phase   = phase_strobe(PhFetch);
                    state_d = StDecode;
                end else if (wd_expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                phase   = phase_strobe(PhDecode);
                state_d = StSel1;
            end
            StSel1: begin
                if (num_of_ope == 4'd0 || num_of_ope > MaxLen) begin
                    state_d = StFault;
                end else if (halt_op) begin
                    state_d = StHalt;
                end else begin
                    phase   = phase_strobe(PhSel1);
                    state_d = StExec1;
                end
            end
            StExec1: begin
                phase   = phase_strobe(PhExec1);
                state_d = (reg_load_2 != 4'd0) ? StSel2 : StWb;
            end
            StSel2: begin
                phase   = phase_strobe(PhSel2);
                state_d = StExec2;
            end
            StExec2: begin
                phase   = phase_strobe(PhExec2);
                state_d = StWb;
            end
            StWb: begin
                phase   = phase_strobe(PhWb);
                state_d = StAdv;
            end
            StAdv: begin
                phase   = phase_strobe(PhAdv);
                state_d = run ? StFetch : StIdle;
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            fetch_req_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_req_q <= (state_d == StFetch);
            busy_q      <= !(state_d inside {StIdle, StHalt, StFault});
            halted_q    <= (state_d == StHalt);
            fault_q     <= (state_d == StFault);
            if (state_q == StAdv) retired_q <= retired_q + 32'd1;
        end
    end

    assign fetch_req = fetch_req_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: phase sequences, run/step control, halt,
// fetch timeout, illegal length and asynchronous reset.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, step, mem_ack, halt_op;
    logic [3:0]  num_of_ope, reg_load_2;
    logic        fetch_req, busy, halted, fault;
    logic [7:0]  phase;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    logic [7:0] seq1 [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h40, 8'h80};
    logic [7:0] seq2 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    instr_sequencer #(
        .FETCH_TIMEOUT (15),
        .MAX_OPE_LEN   (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .mem_ack    (mem_ack),
        .num_of_ope (num_of_ope),
        .reg_load_2 (reg_load_2),
        .halt_op    (halt_op),
        .fetch_req  (fetch_req),
        .phase      (phase),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".phase"}, phase, 0);
        chk({tag, ".fetch_req"}, fetch_req, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".halted"}, halted, 0);
        chk({tag, ".fault"}, fault, 0);
        chk({tag, ".retired"}, retired, 0);
    endtask

    task automatic apply_reset(input string tag);
        run   = 1'b0;
        step  = 1'b0;
        reset = 1'b0;
        nxt();
        chk_reset_state(tag);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; step = 1'b0; mem_ack = 1'b0; halt_op = 1'b0;
        num_of_ope = 4'd2; reg_load_2 = 4'd0;
        nxt();
        chk_reset_state("por");
        reset = 1'b1;

        // Continuous single-stage instructions, zero-wait fetch.
        run = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            nxt();
            chk($sformatf("single.phase[%0d]", i), phase, seq1[i % 6]);
            chk($sformatf("single.retired[%0d]", i), retired, i / 6);
        end
        chk("single.busy", busy, 1);

        // Two-stage instructions.
        reg_load_2 = 4'd3;
        for (int i = 0; i < 16; i++) begin
            nxt();
            chk($sformatf("dual.phase[%0d]", i), phase, seq2[i % 8]);
            chk($sformatf("dual.retired[%0d]", i), retired, 2 + i / 8);
        end

        // Drop run mid-instruction: finishes, then idles.
        nxt(); chk("stop.fetch", phase, 8'h01); chk("stop.retired0", retired, 4);
        nxt(); chk("stop.decode", phase, 8'h02);
        run = 1'b0;
        for (int i = 2; i < 8; i++) begin
            nxt();
            chk($sformatf("stop.phase[%0d]", i), phase, seq2[i]);
        end
        nxt();
        chk("stop.idle_phase", phase, 0);
        chk("stop.idle_busy", busy, 0);
        chk("stop.idle_fetch_req", fetch_req, 0);
        chk("stop.retired1", retired, 5);

        // Single step; a second step while busy is ignored. mem_ack in IDLE ignored.
        num_of_ope = 4'd1; reg_load_2 = 4'd0;
        step = 1'b1;
        nxt(); chk("step.fetch", phase, 8'h01); chk("step.busy", busy, 1);
        step = 1'b0;
        nxt(); chk("step.decode", phase, 8'h02);
        nxt(); chk("step.sel1", phase, 8'h04);
        step = 1'b1;
        nxt(); chk("step.exec1", phase, 8'h08);
        step = 1'b0;
        nxt(); chk("step.wb", phase, 8'h40);
        nxt(); chk("step.adv", phase, 8'h80);
        nxt();
        chk("step.idle_phase", phase, 0);
        chk("step.idle_busy", busy, 0);
        chk("step.retired", retired, 6);
        nxt();
        chk("step.still_idle_phase", phase, 0);
        chk("step.still_idle_fetch_req", fetch_req, 0);
        chk("step.retired_hold", retired, 6);

        // HLT on the third instruction; max legal length used for the first two.
        apply_reset("rst_halt");
        run = 1'b1; mem_ack = 1'b1; num_of_ope = 4'd6; reg_load_2 = 4'd0; halt_op = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nxt();
            chk($sformatf("halt.pre_phase[%0d]", i), phase, seq1[i % 6]);
        end
        nxt(); chk("halt.fetch", phase, 8'h01);
        nxt(); chk("halt.decode", phase, 8'h02);
        halt_op = 1'b1;
        nxt(); chk("halt.sel1_no_strobe", phase, 0);
        nxt();
        chk("halt.halted", halted, 1);
        chk("halt.busy", busy, 0);
        chk("halt.retired", retired, 2);
        chk("halt.phase", phase, 0);
        halt_op = 1'b0;
        nxt(); nxt();
        chk("halt.held", halted, 1);
        chk("halt.held_phase", phase, 0);
        chk("halt.held_fetch_req", fetch_req, 0);

        // Asynchronous reset during EXEC1 of the second instruction.
        apply_reset("rst_exec");
        run = 1'b1; mem_ack = 1'b1; num_of_ope = 4'd2; reg_load_2 = 4'd0;
        for (int i = 0; i < 6; i++) nxt();
        nxt(); nxt(); nxt();
        nxt(); chk("areset.exec1", phase, 8'h08); chk("areset.retired_pre", retired, 1);
        reset = 1'b0;
        #1;
        chk_reset_state("areset.same_cycle");
        nxt();
        chk_reset_state("areset.held");
        run = 1'b0;
        reset = 1'b1;
        nxt();
        chk("areset.after_phase", phase, 0);
        chk("areset.after_retired", retired, 0);

        // Fetch timeout.
        mem_ack = 1'b0; run = 1'b1;
        for (int k = 0; k < 15; k++) begin
            nxt();
            chk($sformatf("tmo.fetch_req[%0d]", k), fetch_req, 1);
            chk($sformatf("tmo.phase[%0d]", k), phase, 0);
            chk($sformatf("tmo.fault[%0d]", k), fault, 0);
        end
        nxt();
        chk("tmo.fault", fault, 1);
        chk("tmo.busy", busy, 0);
        chk("tmo.fetch_req", fetch_req, 0);
        chk("tmo.phase", phase, 0);
        mem_ack = 1'b1;
        nxt(); nxt();
        chk("tmo.held_fault", fault, 1);
        chk("tmo.held_phase", phase, 0);

        // Illegal length 7 faults at SEL1 without the select strobe.
        apply_reset("rst_len");
        run = 1'b1; mem_ack = 1'b1; num_of_ope = 4'd7;
        nxt(); chk("len.fetch", phase, 8'h01);
        nxt(); chk("len.decode", phase, 8'h02);
        nxt(); chk("len.sel1_no_strobe", phase, 0); chk("len.sel1_busy", busy, 1);
        nxt();
        chk("len.fault", fault, 1);
        chk("len.busy", busy, 0);
        chk("len.phase", phase, 0);
        chk("len.retired", retired, 0);

        // Zero length is also illegal.
        apply_reset("rst_len0");
        run = 1'b1; num_of_ope = 4'd0;
        nxt(); nxt(); nxt();
        chk("len0.sel1_no_strobe", phase, 0);
        nxt();
        chk("len0.fault", fault, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
